sync_shift_reg_filt: RTL and testbench

Parametrised successor to the single-bit, fixed-depth synchronizer chain. It brings a WIDTH-bit asynchronous input into the `clock` domain through a DEPTH-stage flop chain with a synchronous reset. An optional per-bit stability filter rejects glitches shorter than FILTER_CYCLES. Per-bit rise and fall strobes are produced. It sits at the clock-domain boundary of tile/uncore consumers: interrupt lines, debug requests and slow status bits.

---
 rtl/sync_shift_reg_filt.sv | 83 ++++++++
 tb/tb_sync_shift_reg_filt.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/sync_shift_reg_filt.sv
// rtl/sync_shift_reg_filt.sv - WIDTH-bit synchronizer chain with optional per-bit glitch filter and edge strobes
module sync_shift_reg_filt #(
  parameter int              WIDTH         = 1,
  parameter int              DEPTH         = 3,
  parameter int              FILTER_CYCLES = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_d,
  output logic [WIDTH-1:0] io_q,
  output logic [WIDTH-1:0] io_rise,
  output logic [WIDTH-1:0] io_fall,
  output logic             io_busy
);

  logic [WIDTH-1:0] stage [DEPTH];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev;

  // Only stage[0] may go metastable; nothing but stage[1] samples it.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) stage[k] <= RESET_VALUE;
    end else begin
      stage[0] <= io_d;
      for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
    end
  end

  assign sync = stage[DEPTH-1];

  generate
    if (FILTER_CYCLES == 0) begin : g_bypass
      assign io_q    = sync;
      assign io_busy = 1'b0;
    end else begin : g_filter
      localparam int            CW   = $clog2(FILTER_CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(FILTER_CYCLES - 1);
      localparam logic [CW-1:0] ONE  = CW'(1);

      logic [CW-1:0]    cnt [WIDTH];
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] active;

      // Any return of sync to q drops the count: no partial credit.
      always_ff @(posedge clock) begin
        if (reset) begin
          q <= RESET_VALUE;
          for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (sync[i] == q[i]) begin
              cnt[i] <= '0;
            end else if (cnt[i] == LAST) begin
              q[i]   <= sync[i];
              cnt[i] <= '0;
            end else begin
              cnt[i] <= cnt[i] + ONE;
            end
          end
        end
      end

      always_comb begin
        active = '0;
        for (int i = 0; i < WIDTH; i++) active[i] = (cnt[i] != '0);
      end

      assign io_q    = q;
      assign io_busy = |active;
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) prev <= RESET_VALUE;
    else       prev <= io_q;
  end

  assign io_rise = io_q & ~prev;
  assign io_fall = ~io_q & prev;

endmodule

// File: tb/tb_sync_shift_reg_filt.sv
// tb/tb_sync_shift_reg_filt.sv - directed checks of sync_shift_reg_filt across several parameter sets
module tb_sync_shift_reg_filt;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // a: WIDTH=4 DEPTH=3 F=0 RV=A
  logic       rst_a;
  logic [3:0] d_a, q_a, rise_a, fall_a;
  logic       busy_a;
  sync_shift_reg_filt #(.WIDTH(4), .DEPTH(3), .FILTER_CYCLES(0), .RESET_VALUE(4'hA)) u_a (
    .clock(clock), .reset(rst_a), .io_d(d_a), .io_q(q_a),
    .io_rise(rise_a), .io_fall(fall_a), .io_busy(busy_a));

  // b: WIDTH=1 DEPTH=2 F=4
  logic rst_b, d_b, q_b, rise_b, fall_b, busy_b;
  sync_shift_reg_filt #(.WIDTH(1), .DEPTH(2), .FILTER_CYCLES(4), .RESET_VALUE(1'b0)) u_b (
    .clock(clock), .reset(rst_b), .io_d(d_b), .io_q(q_b),
    .io_rise(rise_b), .io_fall(fall_b), .io_busy(busy_b));

  // c: WIDTH=1 DEPTH=2 F=8
  logic rst_c, d_c, q_c, rise_c, fall_c, busy_c;
  sync_shift_reg_filt #(.WIDTH(1), .DEPTH(2), .FILTER_CYCLES(8), .RESET_VALUE(1'b0)) u_c (
    .clock(clock), .reset(rst_c), .io_d(d_c), .io_q(q_c),
    .io_rise(rise_c), .io_fall(fall_c), .io_busy(busy_c));

  // d: WIDTH=2 DEPTH=3 F=2
  logic       rst_d;
  logic [1:0] d_d, q_d, rise_d, fall_d;
  logic       busy_d;
  sync_shift_reg_filt #(.WIDTH(2), .DEPTH(3), .FILTER_CYCLES(2), .RESET_VALUE(2'b00)) u_d (
    .clock(clock), .reset(rst_d), .io_d(d_d), .io_q(q_d),
    .io_rise(rise_d), .io_fall(fall_d), .io_busy(busy_d));

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One-bit vectors: bit k-1 holds the value driven before / seen after edge k.
  task automatic run_b(input string name, input int n, input logic [15:0] dv, input logic [15:0] qv,
                       input logic [15:0] rv, input logic [15:0] fv, input logic [15:0] bv);
    for (int k = 1; k <= n; k++) begin
      d_b = dv[k-1];
      tick();
      check($sformatf("%s_q_e%0d", name, k),    32'(q_b),    32'(qv[k-1]));
      check($sformatf("%s_rise_e%0d", name, k), 32'(rise_b), 32'(rv[k-1]));
      check($sformatf("%s_fall_e%0d", name, k), 32'(fall_b), 32'(fv[k-1]));
      check($sformatf("%s_busy_e%0d", name, k), 32'(busy_b), 32'(bv[k-1]));
    end
  endtask

  initial begin
    logic [15:0] d0v, d1v, q0v, q1v, r0v, r1v, f0v, f1v, bdv;

    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1; rst_d = 1'b1;
    d_a = 4'h5; d_b = 1'b0; d_c = 1'b0; d_d = 2'b00;
    repeat (3) tick();

    check("rst_q_a",    32'(q_a),    32'hA);
    check("rst_rise_a", 32'(rise_a), 32'h0);
    check("rst_fall_a", 32'(fall_a), 32'h0);
    check("rst_busy_a", 32'(busy_a), 32'h0);
    check("rst_q_b",    32'(q_b),    32'h0);
    check("rst_busy_b", 32'(busy_b), 32'h0);

    // Release: io_q follows io_d exactly DEPTH edges later.
    rst_a = 1'b0; rst_b = 1'b0; rst_d = 1'b0;
    tick(); check("rel_q_e1", 32'(q_a), 32'hA);
    tick(); check("rel_q_e2", 32'(q_a), 32'hA);
    tick();
    check("rel_q_e3",    32'(q_a),    32'h5);
    check("rel_rise_e3", 32'(rise_a), 32'h5);
    check("rel_fall_e3", 32'(fall_a), 32'hA);
    tick();
    check("rel_rise_e4", 32'(rise_a), 32'h0);
    check("rel_fall_e4", 32'(fall_a), 32'h0);

    // Unfiltered latency on bit 0.
    d_a = 4'h4;
    repeat (3) tick();
    check("lat_fall0", 32'(fall_a), 32'h1);
    tick();
    d_a = 4'h5;
    tick(); check("lat_q_e1", 32'(q_a), 32'h4);
    tick(); check("lat_q_e2", 32'(q_a), 32'h4);
    tick();
    check("lat_q_e3",    32'(q_a),    32'h5);
    check("lat_rise_e3", 32'(rise_a), 32'h1);
    tick();
    check("lat_rise_e4", 32'(rise_a), 32'h0);
    check("lat_busy_a",  32'(busy_a), 32'h0);

    // Filter F=4: 3-cycle pulse rejected, 5-cycle pulse passes.
    run_b("rej",  7,  16'h0007, 16'h0000, 16'h0000, 16'h0000, 16'h001C);
    run_b("pass", 12, 16'h001F, 16'h03E0, 16'h0020, 16'h0400, 16'h039C);
    // Chatter 1,1,1,0,1,1,1,1: count restarts after the 0.
    run_b("chat", 16, 16'h00F7, 16'h1E00, 16'h0200, 16'h2000, 16'h1DDC);

    // Reset mid-count, F=8.
    rst_c = 1'b0;
    d_c = 1'b1;
    repeat (7) tick();
    check("mid_busy_cnt5", 32'(busy_c), 32'h1);
    check("mid_q_cnt5",    32'(q_c),    32'h0);
    rst_c = 1'b1;
    tick();
    check("mid_rst_q",    32'(q_c),    32'h0);
    check("mid_rst_busy", 32'(busy_c), 32'h0);
    check("mid_rst_rise", 32'(rise_c), 32'h0);
    rst_c = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("mid_q_e%0d", k),    32'(q_c),    32'(k >= 10));
      check($sformatf("mid_rise_e%0d", k), 32'(rise_c), 32'(k == 10));
      check($sformatf("mid_busy_e%0d", k), 32'(busy_c), 32'(k >= 3 && k <= 9));
    end

    // Independent bits, F=2, DEPTH=3; bit 1 carries a one-cycle glitch.
    d0v = 16'h003F; d1v = 16'hFDFC;
    q0v = 16'h03F0; q1v = 16'hFFC0;
    r0v = 16'h0010; r1v = 16'h0040;
    f0v = 16'h0400; f1v = 16'h0000;
    bdv = 16'h1228;
    for (int k = 1; k <= 16; k++) begin
      d_d = {d1v[k-1], d0v[k-1]};
      tick();
      check($sformatf("ind_q_e%0d", k),    32'(q_d),    32'({q1v[k-1], q0v[k-1]}));
      check($sformatf("ind_rise_e%0d", k), 32'(rise_d), 32'({r1v[k-1], r0v[k-1]}));
      check($sformatf("ind_fall_e%0d", k), 32'(fall_d), 32'({f1v[k-1], f0v[k-1]}));
      check($sformatf("ind_busy_e%0d", k), 32'(busy_d), 32'(bdv[k-1]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
